// File: rtl/vector_mem_serializer.sv
// Serializes R-lane vector loads/stores into R byte accesses on a sync-read RAM, stalling the pipeline meanwhile.
// Optional range check: define MEM_RANGE_CHECK_EN to reject vectors crossing the top of RAM (AccessErr pulse).
module vector_mem_serializer #(
  parameter int I     = 32,
  parameter int N     = 8,
  parameter int R     = 6,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWriteM,
  input  logic                     MemReadM,
  input  logic [I-1:0]             AddressM,
  input  logic [R-1:0][N-1:0]      WriteDataM,
  output logic [R-1:0][N-1:0]      ReadData,
  output logic                     Stall,
  output logic                     AccessErr,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [N-1:0]             mem_wdata,
  output logic                     mem_we,
  input  logic [N-1:0]             mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(R+1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [I-1:0]        base;
  logic [R-1:0][N-1:0] lanes;
  logic [R-1:0][N-1:0] shadow;
  logic [R-1:0][N-1:0] shadowNext;
  logic [AW-1:0]       nextAddr;
  logic                req;
  logic                outOfRange;

  assign req      = MemWriteM | MemReadM;
  assign Stall    = (state == WRITE) || (state == READ) || ((state == IDLE) && req);
  assign nextAddr = AW'(base + I'(cnt) + I'(1));

  // RAM data arriving this cycle belongs to the address issued one cycle earlier.
  always_comb begin
    shadowNext = shadow;
    if (cnt != '0) shadowNext[cnt - CW'(1)] = mem_rdata;
  end

`ifdef MEM_RANGE_CHECK_EN
  logic accessErrQ;

  assign outOfRange = ({1'b0, AddressM} + (I+1)'(R)) > (I+1)'(DEPTH);
  assign AccessErr  = accessErrQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) accessErrQ <= 1'b0;
    else       accessErrQ <= (state == IDLE) && req && outOfRange;
  end
`else
  assign outOfRange = 1'b0;
  assign AccessErr  = 1'b0;
`endif

  // RAM-side outputs are registered one step ahead so they line up with cnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      lanes     <= '0;
      shadow    <= '0;
      ReadData  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            base  <= AddressM;
            lanes <= WriteDataM;
            cnt   <= '0;
            if (outOfRange) begin
              state <= DONE;
              if (!MemWriteM) ReadData <= '0;
            end else if (MemWriteM) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= AddressM[AW-1:0];
              mem_wdata <= WriteDataM[0];
            end else begin
              state    <= READ;
              mem_addr <= AddressM[AW-1:0];
            end
          end
        end
        WRITE: begin
          if (cnt == CW'(R-1)) begin
            state  <= DONE;
            mem_we <= 1'b0;
          end else begin
            cnt       <= cnt + CW'(1);
            mem_addr  <= nextAddr;
            mem_wdata <= lanes[cnt + CW'(1)];
          end
        end
        READ: begin
          shadow <= shadowNext;
          if (cnt == CW'(R)) begin
            state    <= DONE;
            ReadData <= shadowNext;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt < CW'(R-1)) mem_addr <= nextAddr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_mem_serializer.sv
// Directed bench for vector_mem_serializer (R=6, N=8, DEPTH=1024) with a byte-wide sync-read RAM model.
module tb_vector_mem_serializer;
  logic            clk = 1'b0;
  logic            reset;
  logic            MemWriteM, MemReadM;
  logic [31:0]     AddressM;
  logic [5:0][7:0] WriteDataM;
  logic [5:0][7:0] ReadData;
  logic            Stall, AccessErr, mem_we;
  logic [9:0]      mem_addr;
  logic [7:0]      mem_wdata, mem_rdata;

  logic [7:0] ram [1024];
  logic [9:0] wrAddrQ [$];
  logic [7:0] wrDatQ [$];
  logic [9:0] addrLog [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vector_mem_serializer dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .AddressM(AddressM), .WriteDataM(WriteDataM), .ReadData(ReadData), .Stall(Stall),
    .AccessErr(AccessErr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wrAddrQ.push_back(mem_addr);
      wrDatQ.push_back(mem_wdata);
    end
    mem_rdata <= ram[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "timeout");
  end

  // Issues one request and returns in the following DONE cycle; n = stalled cycles.
  task automatic doOp(input logic w, input logic r, input logic [31:0] a, input logic [47:0] d,
                      input logic hold, output int n);
    @(negedge clk);
    MemWriteM = w; MemReadM = r; AddressM = a; WriteDataM = d;
    n = 0;
    #1;
    while (Stall && n < 40) begin
      addrLog[n] = mem_addr;
      n++;
      @(negedge clk);
      if (!hold) begin MemWriteM = 1'b0; MemReadM = 1'b0; end
      #1;
    end
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL op_timeout Stall still %b after %0d cycles", Stall, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; MemWriteM = 1'b0; MemReadM = 1'b0; AddressM = '0; WriteDataM = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({Stall, mem_we, AccessErr} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl got Stall/we/err=%b want 000", {Stall, mem_we, AccessErr});
    end
    checks++;
    if (mem_addr !== 10'h0 || mem_wdata !== 8'h0) begin
      errors++; $display("FAIL reset_mem got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (ReadData !== 48'h0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", ReadData);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++; $display("FAIL idle_stall got %b want 0", Stall);
    end
  endtask

  task automatic test_store_load;
    int n, s;
    s = wrAddrQ.size();
    doOp(1'b1, 1'b0, 32'h10, 48'h060504030201, 1'b0, n);
    checks++;
    if (n !== 7) begin errors++; $display("FAIL store_stall got %0d want 7", n); end
    checks++;
    if (wrAddrQ.size() - s !== 6) begin
      errors++; $display("FAIL store_count got %0d want 6", wrAddrQ.size() - s);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wrAddrQ[s+i] !== 10'(16 + i) || wrDatQ[s+i] !== 8'(i + 1)) begin
        errors++; $display("FAIL store_wr%0d got %h:%h want %h:%h", i, wrAddrQ[s+i], wrDatQ[s+i], 10'(16 + i), 8'(i + 1));
      end
    end
    checks++;
    if (ReadData !== 48'h0) begin errors++; $display("FAIL store_rdata got %h want 0", ReadData); end
    doOp(1'b0, 1'b1, 32'h10, 48'h0, 1'b0, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL load_stall got %0d want 8", n); end
    checks++;
    if (ReadData !== 48'h060504030201) begin
      errors++; $display("FAIL load_rdata got %h want 060504030201", ReadData);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (addrLog[1+i] !== 10'(16 + i)) begin
        errors++; $display("FAIL load_addr%0d got %h want %h", i, addrLog[1+i], 10'(16 + i));
      end
    end
  endtask

  task automatic test_both;
    int n, s;
    s = wrAddrQ.size();
    doOp(1'b1, 1'b1, 32'h40, 48'h363534333231, 1'b0, n);
    checks++;
    if (n !== 7) begin errors++; $display("FAIL both_stall got %0d want 7", n); end
    checks++;
    if (wrAddrQ.size() - s !== 6) begin
      errors++; $display("FAIL both_count got %0d want 6", wrAddrQ.size() - s);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wrAddrQ[s+i] !== 10'(64 + i) || wrDatQ[s+i] !== 8'(8'h31 + i)) begin
        errors++; $display("FAIL both_wr%0d got %h:%h", i, wrAddrQ[s+i], wrDatQ[s+i]);
      end
    end
    checks++;
    if (ReadData !== 48'h060504030201) begin
      errors++; $display("FAIL both_rdata got %h want 060504030201", ReadData);
    end
  endtask

  task automatic test_hold;
    int n, s, k;
    s = wrAddrQ.size();
    doOp(1'b1, 1'b0, 32'h80, 48'h565554535251, 1'b1, n);
    checks++;
    if (n !== 7) begin errors++; $display("FAIL hold_stall got %0d want 7", n); end
    checks++;
    if (wrAddrQ.size() - s !== 6) begin
      errors++; $display("FAIL hold_first got %0d writes want 6", wrAddrQ.size() - s);
    end
    @(negedge clk);
    #1;
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL hold_reaccept got Stall=%b want 1", Stall); end
    @(posedge clk);
    #1;
    MemWriteM = 1'b0;
    k = 0;
    while (Stall && k < 40) begin @(negedge clk); #1; k++; end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (wrAddrQ.size() - s !== 12) begin
      errors++; $display("FAIL hold_total got %0d writes want 12", wrAddrQ.size() - s);
    end
  endtask

  task automatic test_wrap;
    int n, s;
    s = wrAddrQ.size();
`ifdef MEM_RANGE_CHECK_EN
    doOp(1'b0, 1'b1, 32'h3FD, 48'h0, 1'b0, n);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL range_stall got %0d want 1", n); end
    checks++;
    if (AccessErr !== 1'b1) begin errors++; $display("FAIL range_err got %b want 1", AccessErr); end
    checks++;
    if (ReadData !== 48'h0) begin errors++; $display("FAIL range_rdata got %h want 0", ReadData); end
    @(negedge clk);
    #1;
    checks++;
    if (AccessErr !== 1'b0) begin errors++; $display("FAIL range_pulse got %b want 0", AccessErr); end
    doOp(1'b1, 1'b0, 32'h3FD, 48'hC6C5C4C3C2C1, 1'b0, n);
    checks++;
    if (n !== 1 || wrAddrQ.size() !== s) begin
      errors++; $display("FAIL range_store got stall=%0d writes=%0d want 1/0", n, wrAddrQ.size() - s);
    end
`else
    doOp(1'b1, 1'b0, 32'h3FD, 48'hC6C5C4C3C2C1, 1'b0, n);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (wrAddrQ[s+i] !== 10'(32'h3FD + i)) begin
        errors++; $display("FAIL wrap_wr%0d got %h want %h", i, wrAddrQ[s+i], 10'(32'h3FD + i));
      end
    end
    doOp(1'b0, 1'b1, 32'h3FD, 48'h0, 1'b0, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL wrap_stall got %0d want 8", n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (addrLog[1+i] !== 10'(32'h3FD + i)) begin
        errors++; $display("FAIL wrap_addr%0d got %h want %h", i, addrLog[1+i], 10'(32'h3FD + i));
      end
    end
    checks++;
    if (ReadData !== 48'hC6C5C4C3C2C1 || AccessErr !== 1'b0) begin
      errors++; $display("FAIL wrap_rdata got %h err=%b want C6C5C4C3C2C1 err=0", ReadData, AccessErr);
    end
`endif
    // base+R == DEPTH is still in range
    doOp(1'b0, 1'b1, 32'h3FA, 48'h0, 1'b0, n);
    checks++;
    if (n !== 8 || AccessErr !== 1'b0) begin
      errors++; $display("FAIL edge_load got stall=%0d err=%b want 8/0", n, AccessErr);
    end
  endtask

  task automatic test_reset_midwrite;
    int n, s;
    doOp(1'b1, 1'b0, 32'h20, 48'hA5A4A3A2A1A0, 1'b0, n);
    doOp(1'b0, 1'b1, 32'h10, 48'h0, 1'b0, n);
    checks++;
    if (ReadData !== 48'h060504030201) begin
      errors++; $display("FAIL pre_reset_rdata got %h want 060504030201", ReadData);
    end
    s = wrAddrQ.size();
    @(negedge clk);
    MemWriteM = 1'b1; AddressM = 32'h20; WriteDataM = 48'h161514131211;
    @(posedge clk);
    @(negedge clk);
    MemWriteM = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got Stall=%b we=%b want 0/0", Stall, mem_we);
    end
    checks++;
    if (ReadData !== 48'h0) begin errors++; $display("FAIL midrst_rdata got %h want 0", ReadData); end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (wrAddrQ.size() - s !== 3) begin
      errors++; $display("FAIL midrst_count got %0d writes want 3", wrAddrQ.size() - s);
    end
    checks++;
    if ({ram[37], ram[36], ram[35], ram[34], ram[33], ram[32]} !== 48'hA5A4A3131211) begin
      errors++; $display("FAIL midrst_ram got %h want A5A4A3131211", {ram[37], ram[36], ram[35], ram[34], ram[33], ram[32]});
    end
    doOp(1'b0, 1'b1, 32'h20, 48'h0, 1'b0, n);
    checks++;
    if (ReadData !== 48'hA5A4A3131211) begin
      errors++; $display("FAIL midrst_load got %h want A5A4A3131211", ReadData);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_both();
    test_hold();
    test_wrap();
    test_reset_midwrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
